// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: pipeline stage register with a valid/ready handshake, a
// two-entry skid buffer and a synchronous flush.
//
// in_ready comes straight from stored state, so downstream ready never reaches
// upstream ready through a combinational path. The stage still sustains one
// beat per cycle. The main register always holds the oldest beat and drives
// the output. The skid register catches the one beat that can arrive after
// downstream first stalls.
//
// Optional feature, enabled by defining PIPE_SKID_REG_STALL_CNT_EN:
// stall_cnt counts the cycles where out_valid is high and out_ready is low.
// The counter saturates and is cleared only by rst. When the macro is not
// defined, the design has no counter flops and stall_cnt is tied to zero.
module pipe_skid_reg #(
  parameter int DATA_W = 73,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Occupancy of the stage. main_v and skid_v are decoded from this state,
  // so the illegal combination "skid full, main empty" cannot be encoded.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic              main_v;
  logic              skid_v;
  logic              in_fire;
  logic              out_fire;

  assign main_v    = (state != EMPTY);
  assign skid_v    = (state == FULL);
  assign out_valid = main_v;
  assign out_data  = main_data;
  assign in_ready  = !skid_v;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Occupancy FSM and payload registers. rst has priority over flush, and
  // flush has priority over both handshakes.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments. Every branch
    // below then reads the values from before the clock edge, which matches
    // what the hardware flops do.
    if (rst) begin
      state     <= EMPTY;
      // NOTE: the payload registers are reset as well, because out_data is
      // required to read zero after reset. flush clears only the valid
      // state, which keeps the wide data path off the flush net.
      main_data <= '0;
      skid_data <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_data <= in_data;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_data <= in_data;
          end else if (in_fire) begin
            skid_data <= in_data;
            state     <= FULL;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_data <= skid_data;
            state     <= BUSY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef PIPE_SKID_REG_STALL_CNT_EN
  // Saturating count of backpressured cycles. flush does not touch it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: scoreboard bench for pipe_skid_reg.
// The reference model treats the stage as a FIFO that holds at most two beats.
// The stimulus process pushes each accepted beat into the FIFO. A flush or a
// reset empties the FIFO. A separate monitor runs on the falling edge. It
// compares the DUT outputs against the FIFO and pops the head on each
// downstream transfer.
module tb_pipe_skid_reg;

  localparam int DATA_W = 73;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;

  pipe_skid_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference state.
  logic [DATA_W-1:0] exp_q[$];
  int                model_stall;
  bit                mdl_in_ready;
  bit                exp_zero_data;
  bit                mon_en;
  bit                held;
  int                n_cmp;
  int                n_fail;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor. It samples in the middle of the cycle, away from the rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("out_valid", out_valid, (exp_q.size() != 0));
      check("in_ready", in_ready, (exp_q.size() < 2));
      check("stall_cnt", stall_cnt, model_stall);
      if (exp_zero_data) check("out_data_after_rst", out_data, '0);
      if (exp_q.size() != 0 && out_valid === 1'b1) check("out_data", out_data, exp_q[0]);
      mdl_in_ready = (exp_q.size() < 2);
`ifdef PIPE_SKID_REG_STALL_CNT_EN
      if (exp_q.size() != 0 && !out_ready && model_stall < CNT_MAX) model_stall++;
`endif
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
    end
  end

  // Drive one clock cycle of inputs, then update the model with what the
  // stage accepted at the next rising edge.
  task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input bit ordy,
                       input bit fl, input bit r);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    @(negedge clk);
    #1;
    if (r) begin
      exp_q.delete();
      model_stall   = 0;
      exp_zero_data = 1'b1;
      held          = 1'b0;
    end else begin
      if (v && mdl_in_ready) exp_zero_data = 1'b0;
      held = v && !mdl_in_ready;
      if (fl) exp_q.delete();
      else if (v && mdl_in_ready) exp_q.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  logic [DATA_W-1:0] rd;
  bit                rv;

  initial begin
    n_cmp = 0;
    n_fail = 0;
    model_stall = 0;
    mdl_in_ready = 1'b1;
    mon_en = 1'b0;
    held = 1'b0;
    exp_zero_data = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    mon_en = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Streaming 1..10 at full rate.
    for (int i = 1; i <= 10; i++) cycle(1'b1, DATA_W'(i), 1'b1, 1'b0, 1'b0);
    idle(3);

    // Backpressure: A and B are accepted, C waits until downstream drains.
    cycle(1'b1, DATA_W'('hA), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, DATA_W'('hB), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, DATA_W'('hC), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, DATA_W'('hC), 1'b1, 1'b0, 1'b0);
    cycle(1'b1, DATA_W'('hC), 1'b1, 1'b0, 1'b0);
    idle(3);

    // Flush while the stage is full. The concurrent beat C is discarded.
    cycle(1'b1, DATA_W'('h1A), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, DATA_W'('h1B), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, DATA_W'('h1C), 1'b0, 1'b1, 1'b0);
    idle(3);

    // Reset while the stage is full, then send one normal beat.
    cycle(1'b1, DATA_W'('h2A), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, DATA_W'('h2B), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, DATA_W'('h2C), 1'b0, 1'b0, 1'b1);
    cycle(1'b1, DATA_W'('h2D), 1'b1, 1'b0, 1'b0);
    idle(3);

    // Counter saturation: hold one beat with out_ready low for 20 cycles.
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, DATA_W'('h3A), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Randomized traffic with occasional flush and reset. A beat that was
    // not accepted is held unchanged on the input.
    rv = 1'b0;
    rd = '0;
    for (int i = 0; i < 2000; i++) begin
      if (!held) begin
        rv = ($urandom_range(0, 9) < 6);
        rd = {$urandom, $urandom, $urandom};
      end
      cycle(rv, rd, ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 149) == 0));
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline stage register with valid/ready handshake, a two-entry skid buffer, and synchronous flush. It sits between any two pipeline stages of the CPU, including EX→MEM and MEM→WB, and carries a packed control+data payload. Unlike a plain enable-gated stage latch, it supports per-stage backpressure at full throughput, with no combinational path from downstream ready to upstream ready. It also supports squashing of in-flight contents on branch/exception flush.

## Interface
Parameters:
- DATA_W, 73, payload width; the default is sized for the packed {WB[1:0], MEM[1:0], alu[31:0], RD2[31:0], WN[4:0]} bundle.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream has payload.
- in_ready  output  1  stage can accept; registered, depends on state only.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  stage presents payload.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  payload, driven directly from the main register.
- stall_cnt  output  CNT_W  count of backpressured cycles (see Configuration).

## Operation
- Storage: main register (main_data, main_v) and skid register (skid_data, skid_v).
- out_valid = main_v; out_data = main_data; in_ready = !skid_v.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Upstream must hold in_data stable while in_valid & !in_ready. The block holds out_data stable while out_valid & !out_ready.
- States: EMPTY (!main_v, !skid_v), BUSY (main_v, !skid_v), FULL (main_v, skid_v). The state !main_v & skid_v is illegal and never reached.
- EMPTY: in_fire → main←in_data, BUSY. Otherwise stay in EMPTY.
- BUSY, in_fire & out_fire → main←in_data, stay in BUSY.
- BUSY, in_fire only → skid←in_data, FULL.
- BUSY, out_fire only → EMPTY.
- BUSY, neither → hold.
- FULL: in_ready=0. out_fire → main←skid, skid_v←0, BUSY. Otherwise hold.
- Ordering is strict FIFO; no payload is duplicated or dropped except by flush or rst.
- Flush has priority over all handshakes in the same cycle. It sets main_v←0 and skid_v←0, giving EMPTY.
  - A concurrent in_fire is discarded.
  - A concurrent out_fire is still considered taken by downstream.
  - Data registers are not cleared by flush.
- rst has priority over flush. It clears main_v, skid_v, main_data, skid_data and the stall counter.

## Timing
- Reset values: out_valid=0, out_data=0, in_ready=1, stall_cnt=0.
- Latency: in_fire at cycle N → out_valid=1 with that payload at N+1 (EMPTY or BUSY with simultaneous out_fire).
- Throughput: one transfer per cycle sustained while out_ready=1.
- in_ready deasserts the cycle after the skid fills. It reasserts the cycle after out_fire in FULL.
- Maximum occupancy is 2. At most one beat is accepted after downstream first stalls.
- Flush at cycle N → out_valid=0 and in_ready=1 at N+1.
- rst asserted mid-transfer: the next cycle shows reset values. Nothing accepted in the rst cycle is retained.

## Configuration
- Macro: PIPE_SKID_REG_STALL_CNT_EN.
- Defined: stall_cnt increments by 1 each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W−1.
  - Cleared only by rst; flush does not affect it.
- Undefined: no counter flops; stall_cnt is driven constant 0. The port list is unchanged.

## Test plan
- Streaming: rst, then out_ready=1 and in_valid=1 with data 1,2,3,…,10 on consecutive cycles → out_data 1..10 on consecutive cycles, each one cycle after its accept; in_ready stays 1.
- Backpressure: out_ready=0 while sending A, B, C.
  - A and B are accepted; in_ready=0 from the cycle after B is accepted, so C is held.
  - After out_ready=1: outputs A, B, C in order with no loss.
  - With the macro defined, stall_cnt equals the number of stalled cycles (for 4 stall cycles, stall_cnt=4).
- Flush in FULL: hold A, B with out_ready=0; assert flush together with in_valid (C) → next cycle out_valid=0 and in_ready=1; C is never output.
- Reset mid-operation: in FULL, assert rst for 1 cycle → out_valid=0, out_data=0, in_ready=1, stall_cnt=0; the next accepted beat emerges normally.
- Saturation: build with CNT_W=4 and the macro defined; hold out_valid with out_ready=0 for 20 cycles → stall_cnt=15. Without the macro → stall_cnt=0 throughout.
